bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 167 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-port (data, fetch) Wishbone classic master arbiter with fixed data-first priority.
// Optional ack timeout is built in when BUS_ARB_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | no bus cycle; grants a pending data request, else a pending fetch
// BUS_DM | data access on the bus, waiting for ack
// BUS_IF | fetch access on the bus, waiting for ack
module bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_stallreq_o,

    input  logic        dm_ce_i,
    input  logic        dm_we_i,
    input  logic [3:0]  dm_sel_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_i,
    output logic [31:0] dm_data_o,
    output logic        dm_stallreq_o,

    input  logic        advance_i,
    input  logic        flush_i,

    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_adr_o,
    output logic [31:0] bus_dat_o,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUS_DM = 2'd1,
        BUS_IF = 2'd2
    } state_t;

    state_t      state_q;
    logic        dm_valid_q;
    logic        if_valid_q;
    logic [31:0] if_data_q;
    logic [31:0] dm_data_q;
    logic        bus_cyc_q;
    logic        bus_we_q;
    logic [3:0]  bus_sel_q;
    logic [31:0] bus_adr_q;
    logic [31:0] bus_dat_q;

    logic        xfer_done;
    logic [31:0] xfer_data;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TW-1:0] tmo_cnt_q;
    logic          tmo_hit;

    // Reloaded while idle so every grant starts a fresh wait window.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            tmo_cnt_q <= TW'(TIMEOUT_CYCLES - 1);
        end else if (tmo_cnt_q != '0) begin
            tmo_cnt_q <= tmo_cnt_q - 1'b1;
        end
    end

    assign tmo_hit   = (tmo_cnt_q == '0);
    assign xfer_done = bus_ack_i | tmo_hit;
    assign xfer_data = bus_ack_i ? bus_dat_i : 32'hFFFF_FFFF;
`else
    logic unused_timeout;

    // The limit only matters when the timeout is built in.
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign xfer_done      = bus_ack_i;
    assign xfer_data      = bus_dat_i;
`endif

    assign dm_stallreq_o = dm_ce_i & ~dm_valid_q;
    assign if_stallreq_o = if_ce_i & ~if_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dm_valid_q <= 1'b0;
            if_valid_q <= 1'b0;
            if_data_q  <= 32'h0;
            dm_data_q  <= 32'h0;
            bus_cyc_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_sel_q  <= 4'h0;
            bus_adr_q  <= 32'h0;
            bus_dat_q  <= 32'h0;
        end else if (flush_i) begin
            state_q    <= IDLE;
            dm_valid_q <= 1'b0;
            if_valid_q <= 1'b0;
            bus_cyc_q  <= 1'b0;
        end else begin
            if (advance_i) begin
                dm_valid_q <= 1'b0;
                if_valid_q <= 1'b0;
            end
            // A completing access sets its own flag after the advance clear above.
            case (state_q)
                IDLE: begin
                    if (dm_ce_i && !dm_valid_q) begin
                        state_q   <= BUS_DM;
                        bus_cyc_q <= 1'b1;
                        bus_we_q  <= dm_we_i;
                        bus_sel_q <= dm_sel_i;
                        bus_adr_q <= dm_addr_i;
                        bus_dat_q <= dm_data_i;
                    end else if (if_ce_i && !if_valid_q) begin
                        state_q   <= BUS_IF;
                        bus_cyc_q <= 1'b1;
                        bus_we_q  <= 1'b0;
                        bus_sel_q <= 4'hF;
                        bus_adr_q <= if_addr_i;
                    end
                end
                BUS_DM: begin
                    if (xfer_done) begin
                        state_q    <= IDLE;
                        bus_cyc_q  <= 1'b0;
                        dm_valid_q <= 1'b1;
                        if (!bus_we_q) begin
                            dm_data_q <= xfer_data;
                        end
                    end
                end
                BUS_IF: begin
                    if (xfer_done) begin
                        state_q    <= IDLE;
                        bus_cyc_q  <= 1'b0;
                        if_valid_q <= 1'b1;
                        if_data_q  <= xfer_data;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    bus_cyc_q <= 1'b0;
                end
            endcase
        end
    end

    assign if_data_o = if_data_q;
    assign dm_data_o = dm_data_q;
    assign bus_cyc_o = bus_cyc_q;
    assign bus_stb_o = bus_cyc_q;
    assign bus_we_o  = bus_we_q;
    assign bus_sel_o = bus_sel_q;
    assign bus_adr_o = bus_adr_q;
    assign bus_dat_o = bus_dat_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bus_arbiter;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_ce;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_stall;
    logic        dm_ce;
    logic        dm_we;
    logic [3:0]  dm_sel;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_stall;
    logic        advance;
    logic        flush;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack;

    always #5 clk = ~clk;

    bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .if_ce_i(if_ce), .if_addr_i(if_addr), .if_data_o(if_data), .if_stallreq_o(if_stall),
        .dm_ce_i(dm_ce), .dm_we_i(dm_we), .dm_sel_i(dm_sel), .dm_addr_i(dm_addr),
        .dm_data_i(dm_wdata), .dm_data_o(dm_rdata), .dm_stallreq_o(dm_stall),
        .advance_i(advance), .flush_i(flush),
        .bus_cyc_o(cyc), .bus_stb_o(stb), .bus_we_o(we), .bus_sel_o(sel),
        .bus_adr_o(adr), .bus_dat_o(dat_o), .bus_dat_i(dat_i), .bus_ack_i(ack)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level model: one outstanding access (or none), plus per-port result and flag.
    bit          m_known = 1'b0;
    bit          m_busy;
    bit          m_is_fetch;
    bit          m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_adr, m_dat, m_if_data, m_dm_data;
    bit          m_dm_v, m_if_v;
    int          m_wait;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        if (!m_known) return;
        chk("cyc",      32'(cyc),      32'(m_busy));
        chk("stb",      32'(stb),      32'(m_busy));
        chk("we",       32'(we),       32'(m_we));
        chk("sel",      32'(sel),      32'(m_sel));
        chk("adr",      adr,           m_adr);
        chk("dat_o",    dat_o,         m_dat);
        chk("if_data",  if_data,       m_if_data);
        chk("dm_data",  dm_rdata,      m_dm_data);
        chk("if_stall", 32'(if_stall), 32'(if_ce & ~m_if_v));
        chk("dm_stall", 32'(dm_stall), 32'(dm_ce & ~m_dm_v));
    endtask

    task automatic model_step();
        bit          ndv, niv, done;
        logic [31:0] d;
        if (rst) begin
            m_known = 1'b1; m_busy = 1'b0; m_is_fetch = 1'b0; m_we = 1'b0; m_sel = 4'h0;
            m_adr = 32'h0; m_dat = 32'h0; m_if_data = 32'h0; m_dm_data = 32'h0;
            m_dm_v = 1'b0; m_if_v = 1'b0; m_wait = 0;
        end else if (flush) begin
            m_busy = 1'b0; m_dm_v = 1'b0; m_if_v = 1'b0;
        end else begin
            ndv = advance ? 1'b0 : m_dm_v;
            niv = advance ? 1'b0 : m_if_v;
            if (!m_busy) begin
                if (dm_ce && !m_dm_v) begin
                    m_busy = 1'b1; m_is_fetch = 1'b0; m_we = dm_we; m_sel = dm_sel;
                    m_adr = dm_addr; m_dat = dm_wdata; m_wait = 0;
                end else if (if_ce && !m_if_v) begin
                    m_busy = 1'b1; m_is_fetch = 1'b1; m_we = 1'b0; m_sel = 4'hF;
                    m_adr = if_addr; m_wait = 0;
                end
            end else begin
                done = ack;
                d    = dat_i;
`ifdef BUS_ARB_TIMEOUT_EN
                if (!ack && (m_wait + 1 >= TO)) begin
                    done = 1'b1;
                    d    = 32'hFFFF_FFFF;
                end
                m_wait++;
`endif
                if (done) begin
                    m_busy = 1'b0;
                    if (m_is_fetch) begin
                        m_if_data = d;
                        niv = 1'b1;
                    end else begin
                        if (!m_we) m_dm_data = d;
                        ndv = 1'b1;
                    end
                end
            end
            m_dm_v = ndv;
            m_if_v = niv;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_model();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; if_ce = 1'b0; if_addr = 32'h0; dm_ce = 1'b0; dm_we = 1'b0; dm_sel = 4'h0;
        dm_addr = 32'h0; dm_wdata = 32'h0; advance = 1'b0; flush = 1'b0; dat_i = 32'h0; ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_cyc", 32'(cyc), 32'h0);
        chk("rst_adr", adr, 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);

        // Single fetch with a one-cycle ack
        if_ce = 1'b1; if_addr = 32'h0000_0010;
        tick();
        chk("f_cyc", 32'(cyc), 32'h1);
        chk("f_adr", adr, 32'h0000_0010);
        chk("f_sel", 32'(sel), 32'hF);
        ack = 1'b1; dat_i = 32'h3401_1100;
        tick();
        ack = 1'b0;
        chk("f_data", if_data, 32'h3401_1100);
        chk("f_stall", 32'(if_stall), 32'h0);
        chk("f_cyc_off", 32'(cyc), 32'h0);
        advance = 1'b1;
        tick();
        advance = 1'b0;
        chk("f_adv_stall", 32'(if_stall), 32'h1);
        if_ce = 1'b0;
        tick();

        // Contention: data first, then fetch
        dm_ce = 1'b1; dm_we = 1'b0; dm_sel = 4'hF; dm_addr = 32'h100;
        if_ce = 1'b1; if_addr = 32'h14;
        tick();
        chk("c_adr1", adr, 32'h100);
        chk("c_dm_stall1", 32'(dm_stall), 32'h1);
        ack = 1'b1; dat_i = 32'h1111_2222;
        tick();
        ack = 1'b0;
        chk("c_dm_stall2", 32'(dm_stall), 32'h0);
        chk("c_if_stall2", 32'(if_stall), 32'h1);
        tick();
        chk("c_adr2", adr, 32'h14);
        chk("c_cyc2", 32'(cyc), 32'h1);
        ack = 1'b1; dat_i = 32'h0BBB_BBBB;
        tick();
        ack = 1'b0;
        chk("c_if_stall3", 32'(if_stall), 32'h0);
        chk("c_dm_data", dm_rdata, 32'h1111_2222);
        chk("c_if_data", if_data, 32'h0BBB_BBBB);
        dm_ce = 1'b0; if_ce = 1'b0; advance = 1'b1;
        tick();
        advance = 1'b0;

        // Store leaves load data untouched
        dm_ce = 1'b1; dm_we = 1'b1; dm_sel = 4'b0011; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
        tick();
        chk("s_we", 32'(we), 32'h1);
        chk("s_sel", 32'(sel), 32'h3);
        chk("s_dat", dat_o, 32'hDEAD_BEEF);
        ack = 1'b1; dat_i = 32'h5A5A_5A5A;
        tick();
        ack = 1'b0;
        chk("s_dm_data", dm_rdata, 32'h1111_2222);
        chk("s_stall", 32'(dm_stall), 32'h0);
        dm_ce = 1'b0; dm_we = 1'b0; advance = 1'b1;
        tick();
        advance = 1'b0;

        // Flush colliding with ack in the third fetch cycle
        if_ce = 1'b1; if_addr = 32'h20;
        tick(); tick(); tick();
        chk("fl_cyc_before", 32'(cyc), 32'h1);
        flush = 1'b1; ack = 1'b1; dat_i = 32'h0000_0099;
        tick();
        flush = 1'b0; ack = 1'b0; if_ce = 1'b0;
        chk("fl_cyc", 32'(cyc), 32'h0);
        chk("fl_if_data", if_data, 32'h0BBB_BBBB);
        tick();
        chk("fl_idle", 32'(cyc), 32'h0);

        // Reset in the middle of a data access
        dm_ce = 1'b1; dm_addr = 32'h300; dm_sel = 4'hF;
        tick();
        rst = 1'b1; ack = 1'b1; dat_i = 32'h0000_0055;
        tick();
        rst = 1'b0; ack = 1'b0; dm_ce = 1'b0;
        chk("r_cyc", 32'(cyc), 32'h0);
        chk("r_adr", adr, 32'h0);
        chk("r_dm_data", dm_rdata, 32'h0);
        chk("r_if_data", if_data, 32'h0);
        tick();

`ifdef BUS_ARB_TIMEOUT_EN
        dm_ce = 1'b1; dm_addr = 32'h400;
        tick();
        for (int i = 0; i < TO; i++) tick();
        chk("t_dm_data", dm_rdata, 32'hFFFF_FFFF);
        chk("t_stall", 32'(dm_stall), 32'h0);
        chk("t_cyc", 32'(cyc), 32'h0);
`else
        dm_ce = 1'b1; dm_addr = 32'h400;
        tick();
        for (int i = 0; i < 300; i++) tick();
        chk("w_cyc", 32'(cyc), 32'h1);
        chk("w_stall", 32'(dm_stall), 32'h1);
        ack = 1'b1; dat_i = 32'hCAFE_0001;
        tick();
        ack = 1'b0;
        chk("w_dm_data", dm_rdata, 32'hCAFE_0001);
`endif
        dm_ce = 1'b0; advance = 1'b1;
        tick();
        advance = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            flush    = ($urandom_range(0, 24) == 0);
            advance  = ($urandom_range(0, 3) == 0);
            ack      = ($urandom_range(0, 2) == 0);
            dat_i    = $urandom;
            dm_ce    = ($urandom_range(0, 2) != 0);
            dm_we    = $urandom_range(0, 1) != 0;
            dm_sel   = 4'($urandom);
            dm_addr  = $urandom;
            dm_wdata = $urandom;
            if_ce    = ($urandom_range(0, 2) != 0);
            if_addr  = $urandom;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
